arm_pose_sequencer: RTL

Parametrised multi-channel servo pose sequencer. It owns a programmable table of N_POSES poses, each holding one W-bit position per servo channel. On a start trigger it drives the poses out in order as per-channel DESIRED targets to the existing servo controller instances. It advances to the next pose only once every channel's FLAG has been stable-high for a configurable settle window after a blanking interval. It also provides the shared servo frame counter, loop mode, abort, and a settle timeout fault.

---
 rtl/arm_pose_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/arm_pose_sequencer.sv
// arm_pose_sequencer: drives a programmable table of multi-channel servo poses
// out in order. It advances only after every channel reports at-target for a
// settle window that follows a blanking interval. It also owns the shared servo
// frame counter, loop mode, abort, and a per-pose settle timeout fault.
module arm_pose_sequencer #(
    parameter int N_CH           = 3,
    parameter int N_POSES        = 4,
    parameter int W              = 20,
    parameter int FRAME_CYC      = 2000000,
    parameter int BLANK_CYC      = 4,
    parameter int SETTLE_CYC     = 6,
    parameter int TIMEOUT_FRAMES = 100,
    parameter int PARK_POS       = 1,
    localparam int AW = (N_POSES > 1) ? $clog2(N_POSES) : 1,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              LOOP,
    input  logic              ABORT,
    input  logic              WR_EN,
    input  logic [AW-1:0]     WR_ADDR,
    input  logic [CW-1:0]     WR_CH,
    input  logic [W-1:0]      WR_DATA,
    input  logic [N_CH-1:0]   FLAG,
    output logic [N_CH*W-1:0] DESIRED,
    output logic [27:0]       COUNT,
    output logic [AW-1:0]     STEP,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int BCW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam int SCW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int TCW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

    localparam logic [W-1:0]   PARK_W     = W'(PARK_POS);
    localparam logic [27:0]    COUNT_LAST = 28'(FRAME_CYC - 1);
    localparam logic [AW-1:0]  STEP_LAST  = AW'(N_POSES - 1);
    localparam logic [BCW-1:0] BLANK_N    = BCW'(BLANK_CYC);
    localparam logic [SCW-1:0] SETTLE_N   = SCW'(SETTLE_CYC);
    localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [27:0]         count_q, count_d;
    logic [AW-1:0]       step_q, step_d;
    logic [N_CH*W-1:0]   desired_q, desired_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                start_prev_q, start_prev_d;
    logic [BCW-1:0]      blank_q, blank_d;
    logic [SCW-1:0]      settle_q, settle_d;
    logic [TCW-1:0]      tmo_q, tmo_d;
    logic [W-1:0]        table_q [N_POSES][N_CH];
    logic [W-1:0]        table_d [N_POSES][N_CH];

    logic                start_edge_s;
    logic                frame_wrap_s;
    logic                all_flag_s;
    logic                wr_ok_s;
    logic                load_s;
    logic [AW-1:0]       load_idx_s;
    logic [SCW-1:0]      settle_inc_s;

    // Free-running frame counter and START edge history, independent of state.
    always_comb begin
        frame_wrap_s = (count_q == COUNT_LAST);
        if (frame_wrap_s) begin
            count_d = 28'd0;
        end else begin
            count_d = count_q + 28'd1;
        end
        start_edge_s = START & ~start_prev_q;
        start_prev_d = START;
    end

    // Pose table update; writes outside the table bounds are dropped.
    always_comb begin
        table_d = table_q;
        wr_ok_s = WR_EN && (int'(WR_ADDR) < N_POSES) && (int'(WR_CH) < N_CH);
        if (wr_ok_s) begin
            table_d[WR_ADDR][WR_CH] = WR_DATA;
        end else begin
            table_d = table_q;
        end
    end

    // Sequencer next-state: start, abort, timeout, settle tracking and advance.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        desired_d    = desired_q;
        done_d       = 1'b0;
        err_d        = err_q;
        blank_d      = blank_q;
        settle_d     = settle_q;
        tmo_d        = tmo_q;
        load_s       = 1'b0;
        load_idx_s   = step_q;
        all_flag_s   = &FLAG;
        settle_inc_s = settle_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (start_edge_s) begin
                    state_d    = ST_RUN;
                    step_d     = {AW{1'b0}};
                    err_d      = 1'b0;
                    load_s     = 1'b1;
                    load_idx_s = {AW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    // Freeze STEP/DESIRED where they are; no DONE.
                    state_d = ST_IDLE;
                end else if (frame_wrap_s && (tmo_q == TMO_LAST)) begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                end else begin
                    if (frame_wrap_s) begin
                        tmo_d = tmo_q + 1'b1;
                    end else begin
                        tmo_d = tmo_q;
                    end
                    if (blank_q < BLANK_N) begin
                        // FLAG is still settling after the last load.
                        blank_d = blank_q + 1'b1;
                    end else if (all_flag_s) begin
                        if (settle_inc_s == SETTLE_N) begin
                            if (step_q != STEP_LAST) begin
                                step_d     = step_q + 1'b1;
                                load_s     = 1'b1;
                                load_idx_s = step_q + 1'b1;
                            end else if (LOOP) begin
                                step_d     = {AW{1'b0}};
                                load_s     = 1'b1;
                                load_idx_s = {AW{1'b0}};
                            end else begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            settle_d = settle_inc_s;
                        end
                    end else begin
                        settle_d = {SCW{1'b0}};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load presents the selected pose and restarts the per-pose timers.
        if (load_s) begin
            for (int c = 0; c < N_CH; c++) begin
                desired_d[c*W +: W] = table_q[load_idx_s][c];
            end
            blank_d  = {BCW{1'b0}};
            settle_d = {SCW{1'b0}};
            tmo_d    = {TCW{1'b0}};
        end else begin
            desired_d = desired_q;
        end

        busy_d = (state_d == ST_RUN);
    end

    // State, counters, table and registered outputs with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            count_q      <= 28'd0;
            step_q       <= {AW{1'b0}};
            desired_q    <= {N_CH{PARK_W}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            start_prev_q <= 1'b0;
            blank_q      <= {BCW{1'b0}};
            settle_q     <= {SCW{1'b0}};
            tmo_q        <= {TCW{1'b0}};
            for (int p = 0; p < N_POSES; p++) begin
                for (int c = 0; c < N_CH; c++) begin
                    table_q[p][c] <= PARK_W;
                end
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            step_q       <= step_d;
            desired_q    <= desired_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            start_prev_q <= start_prev_d;
            blank_q      <= blank_d;
            settle_q     <= settle_d;
            tmo_q        <= tmo_d;
            table_q      <= table_d;
        end
    end

    assign DESIRED = desired_q;
    assign COUNT   = count_q;
    assign STEP    = step_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;

endmodule
